// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Holds FSM state encodings and the word-size constant (bytes per word).
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, no reset.
// Ports: clk_i, we_i write strobe, idx_i word index, wdata_i, rdata_o.
module dmem_array #(
  parameter int DEPTH_WORDS = 32,
  parameter int IW          = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Ports: clk_i, rst_i (sync, active-high), req_i/we_i/addr_i/wdata_i request,
// stall_o pipeline freeze, ack_o one-cycle done pulse, rdata_o load data,
// err_o access error (only with DMEM_ERR_EN defined, else constant 0).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam int LSB = $clog2(WORD_BYTES);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           we_q;
  logic           bad_q;
  logic [IW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic [31:0]    arr_rdata;
  logic           arr_we;
  logic           last;
  logic [IW-1:0]  idx;
  logic           hi_nz;
  logic           lo_nz;
  logic           bad_addr;

  assign idx   = addr_i[IW+LSB-1:LSB];
  assign hi_nz = |(addr_i >> (IW + LSB));
  assign lo_nz = |addr_i[LSB-1:0];

`ifdef DMEM_ERR_EN
  assign bad_addr = hi_nz | lo_nz;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = hi_nz | lo_nz;
  assign bad_addr = 1'b0;
`endif

  assign last = (state == ST_WAIT) && (cnt == '0);

  // Gate with reset so an access aborted on its final cycle never commits.
  assign arr_we = last && we_q && !bad_q && !rst_i;

  assign stall_o = !rst_i &&
                   (((state == ST_IDLE) && req_i) ||
                    (state == ST_WAIT));

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (arr_we),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            idx_q   <= idx;
            wdata_q <= wdata_i;
            bad_q   <= bad_addr;
            cnt     <= CNT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_DONE;
            ack_o <= 1'b1;
            err_o <= bad_q;
            if (bad_q)      rdata_o <= '0;
            else if (!we_q) rdata_o <= arr_rdata;
          end
        end
        ST_DONE: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 and LATENCY=1 instances.
// Covers reset, store/load, back-to-back, wrap or error handling.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, req1, we1;
  logic [31:0] addr, wdata, addr1, wdata1;
  logic        stall, ack, err, stall1, ack1, err1;
  logic [31:0] rdata, rdata1;

  int vectors     = 0;
  int miscompares = 0;

  int          lat, stalls;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
    .ack_o(ack), .rdata_o(rdata), .err_o(err)
  );

  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1),
    .addr_i(addr1), .wdata_i(wdata1), .stall_o(stall1),
    .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge while the DUT is idle. Returns the ack
  // cycle offset from the request cycle (-1 on timeout), the number of
  // stalled cycles up to and including the ack cycle, and rdata/err at ack.
  task automatic access(input bit sel, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int l, output int s,
                        output logic [31:0] r, output logic e);
    l = -1; s = 0; r = '0; e = 1'b0;
    if (sel) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else     begin req  = 1; we  = w; addr  = a; wdata  = d; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel ? stall1 : stall) s++;
      if (sel ? ack1 : ack) begin
        l = k;
        r = sel ? rdata1 : rdata;
        e = sel ? err1 : err;
        break;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        if (sel) begin addr1 = ~a; wdata1 = ~d; end
        else     begin addr  = ~a; wdata  = ~d; end
      end
    end
    @(posedge clk); #1;
    req = 0; we = 0; req1 = 0; we1 = 0;
  endtask

  initial begin
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall1", 32'(stall1), 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // store then load
    access(0, 1, 32'h8, 32'hDEADBEEF, lat, stalls, rd, er);
    chk("st_lat", 32'(lat), 32'd5);
    chk("st_stalls", 32'(stalls), 32'd5);
    chk("st_err", 32'(er), 32'd0);
    @(negedge clk);
    chk("ack_pulse", 32'(ack), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    access(0, 0, 32'h8, 32'h0, lat, stalls, rd, er);
    chk("ld_lat", 32'(lat), 32'd5);
    chk("ld_data", rd, 32'hDEADBEEF);

    // store leaves rdata untouched
    access(0, 1, 32'hC, 32'h55, lat, stalls, rd, er);
    chk("st_hold_rdata", rd, 32'hDEADBEEF);

    // back-to-back loads
    access(0, 0, 32'h8, 32'h0, lat, stalls, rd, er);
    chk("b2b0_lat", 32'(lat), 32'd5);
    chk("b2b0_stalls", 32'(stalls), 32'd5);
    chk("b2b0_data", rd, 32'hDEADBEEF);
    access(0, 0, 32'hC, 32'h0, lat, stalls, rd, er);
    chk("b2b1_lat", 32'(lat), 32'd5);
    chk("b2b1_stalls", 32'(stalls), 32'd5);
    chk("b2b1_data", rd, 32'h55);

    // reset mid-WAIT aborts a pending store
    req = 1; we = 1; addr = 32'h8; wdata = 32'h11111111;
    @(negedge clk);
    chk("mid_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; req = 0; we = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_stall2", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    access(0, 0, 32'h8, 32'h0, lat, stalls, rd, er);
    chk("post_rst_data", rd, 32'hDEADBEEF);
    chk("post_rst_lat", 32'(lat), 32'd5);

    // LATENCY=1 instance
    access(1, 1, 32'h10, 32'h77, lat, stalls, rd, er);
    chk("l1_st_lat", 32'(lat), 32'd2);
    chk("l1_st_stalls", 32'(stalls), 32'd2);
    access(1, 0, 32'h10, 32'h0, lat, stalls, rd, er);
    chk("l1_ld_lat", 32'(lat), 32'd2);
    chk("l1_ld_stalls", 32'(stalls), 32'd2);
    chk("l1_ld_data", rd, 32'h77);

`ifdef DMEM_ERR_EN
    access(0, 1, 32'h4, 32'hCAFE, lat, stalls, rd, er);
    chk("e_st_ok_err", 32'(er), 32'd0);
    access(0, 1, 32'h6, 32'hBAD, lat, stalls, rd, er);
    chk("e_mis_err", 32'(er), 32'd1);
    chk("e_mis_lat", 32'(lat), 32'd5);
    @(negedge clk);
    chk("e_err_pulse", 32'(err), 32'd0);
    @(posedge clk); #1;
    access(0, 0, 32'h4, 32'h0, lat, stalls, rd, er);
    chk("e_ld_keep", rd, 32'hCAFE);
    chk("e_ld_err", 32'(er), 32'd0);
    access(0, 0, 32'h100, 32'h0, lat, stalls, rd, er);
    chk("e_oor_data", rd, 32'd0);
    chk("e_oor_err", 32'(er), 32'd1);
    chk("e_oor_lat", 32'(lat), 32'd5);
`else
    access(0, 1, 32'h80, 32'h1234, lat, stalls, rd, er);
    chk("w_st_err", 32'(er), 32'd0);
    access(0, 0, 32'h0, 32'h0, lat, stalls, rd, er);
    chk("w_ld_data", rd, 32'h1234);
    chk("w_ld_err", 32'(er), 32'd0);
    access(0, 0, 32'h2, 32'h0, lat, stalls, rd, er);
    chk("w_mis_data", rd, 32'h1234);
    chk("w_mis_err", 32'(er), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
